// File: rtl/float_pkg.sv
// -----------------------------------------------------------------------------
// float_pkg
//   Shared definitions for the single-precision post-adder normalizer.
//   - FP_EXP_W / FP_MANT_W : IEEE-754 single field widths (defaults for the
//                            parameterised normalizer)
//   - FP_BIAS              : exponent bias
//   - FP_EXP_INF           : all-ones exponent field (infinity / NaN)
//   - state_t              : normalizer control states
//   - pack(), inf()        : assemble a packed {sign, exp, fraction} word
//   - POS_ZERO             : canonical +0
// -----------------------------------------------------------------------------
package float_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  localparam int FP_BIAS   = 127;
  localparam int FP_WORD_W = 1 + FP_EXP_W + FP_MANT_W;

  localparam logic [FP_EXP_W-1:0] FP_EXP_INF = '1;

  typedef logic [FP_WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam word_t POS_ZERO = '0;

  // Assemble a packed single from its three fields.
  function automatic word_t pack(input logic                 sign,
                                 input logic [FP_EXP_W-1:0]  exp,
                                 input logic [FP_MANT_W-1:0] frac);
    return {sign, exp, frac};
  endfunction

  // Signed infinity: all-ones exponent, zero fraction.
  function automatic word_t inf(input logic sign);
    return pack(sign, FP_EXP_INF, '0);
  endfunction

endpackage

// File: rtl/float_normalize.sv
// -----------------------------------------------------------------------------
// float_normalize
//   Iterative normalizer that sits after the float_addition mantissa datapath.
//   Takes the raw sum (sign, larger-operand exponent, mantissa with carry and
//   hidden bits), normalizes it one bit per cycle and emits a packed IEEE-754
//   word over a valid/ready handshake.
//
//   Handles, in priority order each NORM cycle:
//     zero result -> +0, carry-out -> right shift (with overflow to infinity),
//     hidden bit set -> pack, exponent floor reached -> denormal (or +0 when
//     FLUSH_DENORM), otherwise shift left one place and decrement exponent.
//
// Ports
//   clk        clock, all state on posedge
//   rst        asynchronous active-high reset, discards any in-flight work
//   in_valid   raw result present
//   in_ready   block can accept (IDLE and not in reset)
//   in_sign    result sign
//   in_exp     exponent of larger-magnitude operand (0 = denormal operand)
//   in_mant    raw mantissa: [MANT_W+1] carry, [MANT_W] hidden, rest fraction
//   out_valid  packed result available (held until out_ready)
//   out_ready  consumer accepts result
//   out_data   packed {sign, exp, fraction}
// -----------------------------------------------------------------------------
module float_normalize
  import float_pkg::*;
#(
  parameter int EXP_W        = FP_EXP_W,
  parameter int MANT_W       = FP_MANT_W,
  parameter bit FLUSH_DENORM = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [MANT_W+1:0]       in_mant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   out_data
);

  localparam int WORD_W = 1 + EXP_W + MANT_W;

  // Working exponent carries one extra bit so the carry increment of the
  // largest finite exponent cannot wrap before the overflow compare.
  localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);
  localparam logic [EXP_W:0] EXP_SAT = (EXP_W+1)'((1 << EXP_W) - 1);

  state_t              state_q, state_d;
  logic                sign_q,  sign_d;
  logic [EXP_W:0]      exp_q,   exp_d;
  logic [MANT_W+1:0]   mant_q,  mant_d;
  logic [WORD_W-1:0]   data_q,  data_d;

  logic [EXP_W:0]      exp_inc;

  assign exp_inc   = exp_q + EXP_ONE;
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    data_d  = data_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_d  = in_sign;
          // A denormal operand has an effective exponent of 1, not 0.
          exp_d   = (in_exp == '0) ? EXP_ONE : {1'b0, in_exp};
          mant_d  = in_mant;
          state_d = NORM;
        end
      end

      NORM: begin
        if (mant_q == '0) begin
          // Exact cancellation: result is always +0 regardless of sign.
          data_d  = '0;
          state_d = DONE;
        end else if (mant_q[MANT_W+1]) begin
          // Carry out of the adder: one right shift, LSB dropped. After this
          // the hidden bit is set, so the carry path can only fire once.
          if (exp_inc >= EXP_SAT) begin
            data_d = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
          end else begin
            data_d = {sign_q, exp_inc[EXP_W-1:0], mant_q[MANT_W:1]};
          end
          state_d = DONE;
        end else if (mant_q[MANT_W]) begin
          // Normalized. Also covers denormal+denormal growing into exp 1.
          data_d  = {sign_q, exp_q[EXP_W-1:0], mant_q[MANT_W-1:0]};
          state_d = DONE;
        end else if (exp_q == EXP_ONE) begin
          // Exponent floor reached with no hidden bit: denormal result.
          if (FLUSH_DENORM) begin
            data_d = '0;
          end else begin
            data_d = {sign_q, {EXP_W{1'b0}}, mant_q[MANT_W-1:0]};
          end
          state_d = DONE;
        end else begin
          // Cancellation left leading zeros: move one place toward normal.
          mant_d = mant_q << 1;
          exp_d  = exp_q - EXP_ONE;
        end
      end

      DONE: begin
        // Result held until the consumer takes it; new work is only accepted
        // from IDLE, so there is no same-cycle turnaround here.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_float_normalize.sv
// -----------------------------------------------------------------------------
// tb_float_normalize
//   Directed and randomized checks of float_normalize. Two instances share the
//   same stimulus: one keeps denormals, one flushes them to +0. Expected words
//   and latencies come from a value-level reference model of the normalizing
//   rules (leading-one search, exponent floor, overflow to infinity).
// -----------------------------------------------------------------------------
module tb_float_normalize;
  import float_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_ready;

  logic        in_ready_a, out_valid_a;
  logic [31:0] out_data_a;
  logic        in_ready_b, out_valid_b;
  logic [31:0] out_data_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  float_normalize #(.EXP_W(8), .MANT_W(23), .FLUSH_DENORM(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_data  (out_data_a)
  );

  float_normalize #(.EXP_W(8), .MANT_W(23), .FLUSH_DENORM(1'b1)) dut_flush (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_data  (out_data_b)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference: what the normalized value should be, and how many left shifts
  // it takes to get there (which fixes the output latency).
  function automatic void model(input logic s, input logic [7:0] e,
                                input logic [24:0] m, input bit flush,
                                output logic [31:0] word, output int shifts);
    int ee;
    int lead;
    logic [24:0] sh;
    ee     = (e == 8'd0) ? 1 : int'(e);
    shifts = 0;
    lead   = -1;
    word   = POS_ZERO;
    if (m == 25'd0) begin
      word = POS_ZERO;
    end else if (m[24]) begin
      ee = ee + 1;
      if (ee >= 255) word = inf(s);
      else           word = pack(s, 8'(ee), m[23:1]);
    end else begin
      for (int i = 0; i < 24; i++) if (m[i]) lead = i;
      shifts = 23 - lead;
      if (ee - shifts >= 1) begin
        sh   = m << shifts;
        word = pack(s, 8'(ee - shifts), sh[22:0]);
      end else begin
        shifts = ee - 1;
        sh     = m << shifts;
        word   = flush ? POS_ZERO : pack(s, 8'h00, sh[22:0]);
      end
    end
  endfunction

  // One complete transaction. A nonzero 'want' overrides the model's word for
  // the keep-denormal instance (used for hand-computed directed vectors).
  task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                        input logic [24:0] m, input int stall,
                        input bit use_want, input logic [31:0] want);
    logic [31:0] exp_a, exp_b;
    int          n_a, n_b, cyc;
    model(s, e, m, 1'b0, exp_a, n_a);
    model(s, e, m, 1'b1, exp_b, n_b);
    if (use_want) exp_a = want;

    check({tag, " idle in_ready"}, 32'(in_ready_a), 32'd1);
    in_sign   = s;
    in_exp    = e;
    in_mant   = m;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);                       // edge t: accepted
    @(negedge clk);
    in_valid = 1'b0;
    in_mant  = 25'(($urandom));           // upstream data changes; must not matter
    check({tag, " busy in_ready"}, 32'(in_ready_a), 32'd0);

    cyc = 0;
    while (!out_valid_a && cyc < 60) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (!out_valid_a) check({tag, " in_ready low in NORM"}, 32'(in_ready_a), 32'd0);
    end
    check({tag, " latency"}, 32'(cyc), 32'(n_a + 1));
    check({tag, " data"}, out_data_a, exp_a);
    check({tag, " flush valid"}, 32'(out_valid_b), 32'd1);
    check({tag, " flush data"}, out_data_b, exp_b);

    for (int k = 0; k < stall; k++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, " held valid"}, 32'(out_valid_a), 32'd1);
      check({tag, " held data"}, out_data_a, exp_a);
    end

    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " valid drop"}, 32'(out_valid_a), 32'd0);
    check({tag, " ready back"}, 32'(in_ready_a), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rs;
    logic [7:0]  re;
    logic [24:0] rm;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'd0;
    in_mant   = 25'd0;
    out_ready = 1'b0;

    #12;
    check("reset out_valid", 32'(out_valid_a), 32'd0);
    check("reset out_data", out_data_a, 32'd0);
    check("reset in_ready", 32'(in_ready_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-reset in_ready", 32'(in_ready_a), 32'd1);
    @(negedge clk);

    // Directed vectors with hand-computed results.
    run_op("cancel 6.25-1.5", 1'b0, 8'd129, 25'h0980000, 0, 1'b1, 32'h40980000);
    run_op("carry 1.5+1.5",   1'b0, 8'd127, 25'h1800000, 0, 1'b1, 32'h40400000);
    run_op("carry to inf",    1'b0, 8'd254, 25'h1000000, 0, 1'b1, 32'h7F800000);
    run_op("multi-shift",     1'b0, 8'd127, 25'h0200000, 0, 1'b1, 32'h3E800000);
    run_op("neg zero",        1'b1, 8'd130, 25'h0000000, 0, 1'b1, 32'h00000000);
    run_op("denormal",        1'b0, 8'd3,   25'h0000001, 0, 1'b1, 32'h00000004);
    run_op("denorm to normal",1'b1, 8'd0,   25'h0800001, 0, 1'b1, 32'h80800001);
    run_op("backpressure",    1'b1, 8'd127, 25'h0C00000, 5, 1'b1, 32'hBFC00000);

    // Reset while shifting: output must clear without waiting for a clock.
    run_op("pre-reset", 1'b0, 8'd129, 25'h0980000, 0, 1'b1, 32'h40980000);
    in_sign  = 1'b0;
    in_exp   = 8'd127;
    in_mant  = 25'h0200000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid-op rst out_valid", 32'(out_valid_a), 32'd0);
    check("mid-op rst out_data", out_data_a, 32'd0);
    check("mid-op rst in_ready", 32'(in_ready_a), 32'd0);
    check("mid-op rst flush out_data", out_data_b, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("after reset", 1'b0, 8'd127, 25'h0200000, 0, 1'b1, 32'h3E800000);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 150; n++) begin
      rs = 1'($urandom);
      re = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) re = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 5) == 0) re = 8'($urandom_range(250, 255));
      if ($urandom_range(0, 7) == 0) rm = 25'd0;
      else rm = 25'($urandom) >> $urandom_range(0, 24);
      run_op($sformatf("rand %0d", n), rs, re, rm,
             int'($urandom_range(0, 3)), 1'b0, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
